// File: rtl/vec_wb_pkg.sv
// vec_wb_pkg: shared width default, element-width and skid-buffer state types
package vec_wb_pkg;
  localparam int WIDTH_DEF = 512;
  localparam int ELEM_MAX = WIDTH_DEF / 8;
  typedef enum logic [1:0] {SEW8, SEW16, SEW32} sew_e;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_e;
endpackage

// File: rtl/vec_skid_buf.sv
// vec_skid_buf: 2-entry in-order skid buffer with registered head output
module vec_skid_buf
  import vec_wb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout
);
  buf_state_e state, nxt;
  logic [DW-1:0] e1;
  logic push, pop;
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_comb begin
    nxt = state;
    nxt = (state == EMPTY) ? (push ? ONE : EMPTY)
        : (state == ONE) ? ((push == pop) ? ONE : push ? FULL : EMPTY)
        : (pop ? ONE : FULL);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= nxt;
  // dout is the head entry; e1 only holds the second beat while FULL
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dout <= '0;
      e1 <= '0;
    end else begin
      if ((state == EMPTY && push) || (state == ONE && push && pop)) dout <= din;
      else if (state == FULL && pop) dout <= e1;
      if (state == ONE && push && !pop) e1 <= din;
    end
endmodule

// File: rtl/vec_addsub_wb_merge.sv
// vec_addsub_wb_merge: mask/tail merge of adder results into a skid-buffered writeback beat
module vec_addsub_wb_merge
  import vec_wb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             sum_i,
  input  logic [WIDTH-1:0]             old_vd_i,
  input  logic [WIDTH/8-1:0]           mask_i,
  input  logic                         vm_i,
  input  logic [$clog2(WIDTH/8):0]     vl_i,
  input  logic                         sew_16_32,
  input  logic                         sew_32,
  input  logic                         vta_i,
  input  logic                         vma_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             result_o,
  output logic [WIDTH/8-1:0]           be_o
);
  localparam int NB = WIDTH / 8;
  localparam int VW = $clog2(NB) + 1;
  sew_e sew;
  logic [1:0] sh;
  logic [VW-1:0] vlmax, vl_eff;
  logic [WIDTH-1:0] res_d;
  logic [NB-1:0] be_d;
  logic [WIDTH+NB-1:0] dout;
  always_comb begin
    sew = sew_32 ? SEW32 : sew_16_32 ? SEW16 : SEW8;
    sh = 2'(sew);
    vlmax = VW'(NB) >> sh;
    vl_eff = (vl_i > vlmax) ? vlmax : vl_i;
  end
  // each byte resolves its element index by shifting its byte lane by log2(element bytes)
  for (genvar g = 0; g < NB; g++) begin : g_byte
    logic [VW-1:0] idx;
    logic body, act;
    assign idx = VW'(g) >> sh;
    assign body = idx < vl_eff;
    assign act = body & (vm_i | mask_i[idx[VW-2:0]]);
    assign be_d[g] = act;
    assign res_d[8*g +: 8] = act ? sum_i[8*g +: 8]
                           : ((body ? vma_i : vta_i) ? 8'hFF : old_vd_i[8*g +: 8]);
  end
  vec_skid_buf #(.DW(WIDTH + NB)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .din({res_d, be_d}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout(dout)
  );
  assign {result_o, be_o} = dout;
endmodule

// File: tb/tb_vec_addsub_wb_merge.sv
// tb_vec_addsub_wb_merge: randomized and directed checks against an element-level reference model
module tb_vec_addsub_wb_merge;
  localparam int W = 512;
  localparam int NB = W / 8;
  localparam int TW = W + NB;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, vm_i = 1, sew_16_32 = 0, sew_32 = 0, vta_i = 0, vma_i = 0;
  logic out_valid, out_ready = 0;
  logic [W-1:0] sum_i = '0, old_vd_i = '0, result_o;
  logic [NB-1:0] mask_i = '0, be_o;
  logic [6:0] vl_i = '0;
  int checks = 0, errors = 0;
  logic [TW-1:0] q[$];
  logic [TW-1:0] exp_beat;

  always #5 clk = ~clk;

  vec_addsub_wb_merge #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum_i(sum_i), .old_vd_i(old_vd_i), .mask_i(mask_i), .vm_i(vm_i), .vl_i(vl_i),
    .sew_16_32(sew_16_32), .sew_32(sew_32), .vta_i(vta_i), .vma_i(vma_i),
    .out_valid(out_valid), .out_ready(out_ready), .result_o(result_o), .be_o(be_o)
  );

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] model(input logic [W-1:0] s, input logic [W-1:0] o,
      input logic [NB-1:0] m, input logic vm, input logic [6:0] vl,
      input logic s16, input logic s32, input logic ta, input logic ma);
    int eb, vmax, v, b;
    logic act, fill;
    logic [W-1:0] r;
    logic [NB-1:0] be;
    r = '0;
    be = '0;
    eb = s32 ? 4 : s16 ? 2 : 1;
    vmax = NB / eb;
    v = (int'(vl) > vmax) ? vmax : int'(vl);
    for (int i = 0; i < vmax; i++) begin
      act = (i < v) && (vm || m[i]);
      fill = (i < v) ? ma : ta;
      for (int k = 0; k < eb; k++) begin
        b = i * eb + k;
        r[8*b +: 8] = act ? s[8*b +: 8] : fill ? 8'hFF : o[8*b +: 8];
        be[b] = act;
      end
    end
    return {r, be};
  endfunction

  // one clock: compare handshake view with the queue model, then advance to next negedge
  task automatic step();
    bit push, pop;
    push = in_valid && q.size() < 2;
    pop = out_ready && q.size() != 0;
    check("in_ready", TW'(in_ready), TW'(q.size() < 2));
    check("out_valid", TW'(out_valid), TW'(q.size() != 0));
    if (pop) begin
      exp_beat = q.pop_front();
      check("beat", {result_o, be_o}, exp_beat);
    end
    if (push) q.push_back(model(sum_i, old_vd_i, mask_i, vm_i, vl_i, sew_16_32, sew_32, vta_i, vma_i));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [TW-1:0] exp);
    in_valid = 1;
    out_ready = 1;
    step();
    in_valid = 0;
    check(tag, {result_o, be_o}, exp);
    step();
  endtask

  task automatic rnd_beat();
    for (int i = 0; i < W / 32; i++) begin
      sum_i[32*i +: 32] = $urandom;
      old_vd_i[32*i +: 32] = $urandom;
    end
    mask_i = {$urandom, $urandom};
    vm_i = $urandom_range(0, 1);
    vl_i = 7'($urandom_range(0, 80));
    {sew_16_32, sew_32} = 2'($urandom_range(0, 3));
    vta_i = $urandom_range(0, 1);
    vma_i = $urandom_range(0, 1);
  endtask

  initial begin
    #1;
    check("rst_out_valid", TW'(out_valid), '0);
    check("rst_in_ready", TW'(in_ready), TW'(1));
    check("rst_data", {result_o, be_o}, '0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    sum_i = {64{8'h09}};
    vl_i = 64;
    directed("sew8_full", {{64{8'h09}}, {64{1'b1}}});

    {sew_16_32, sew_32} = 2'b11;
    vl_i = 5;
    old_vd_i = {16{32'hDEADBEEF}};
    sum_i = {16{32'h11111111}};
    directed("sew32_vl5", {{11{32'hDEADBEEF}}, {5{32'h11111111}}, 64'h000F_FFFF});

    {sew_16_32, sew_32} = 2'b10;
    vl_i = 4;
    vm_i = 0;
    mask_i = 64'h5;
    vma_i = 1;
    vta_i = 1;
    sum_i = {32{16'h1234}};
    directed("sew16_mask", {{29{16'hFFFF}}, 16'h1234, 16'hFFFF, 16'h1234, 64'h33});

    {sew_16_32, sew_32} = 2'b01;
    vm_i = 1;
    vta_i = 0;
    vma_i = 0;
    vl_i = 100;
    sum_i = {16{32'hCAFE0001}};
    directed("vl_clamp", {{16{32'hCAFE0001}}, {64{1'b1}}});
    vl_i = 0;
    directed("vl_zero", {old_vd_i, 64'h0});

    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      sum_i = {16{32'hA0 + 32'(i)}};
      step();
    end
    check("held_c_ready", TW'(in_ready), '0);
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) in_valid = 0;
      step();
    end
    check("drained", TW'(q.size()), '0);

    out_ready = 0;
    in_valid = 1;
    step();
    step();
    #2 rst_n = 0;
    #1;
    check("mid_rst_valid", TW'(out_valid), '0);
    check("mid_rst_ready", TW'(in_ready), TW'(1));
    check("mid_rst_data", {result_o, be_o}, '0);
    q.delete();
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 3; i++) step();

    for (int n = 0; n < 400; n++) begin
      if (!(in_valid && q.size() >= 2)) begin
        in_valid = $urandom_range(0, 3) != 0;
        rnd_beat();
      end
      out_ready = $urandom_range(0, 2) != 0;
      step();
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) step();
    check("final_empty", TW'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
